// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 hex keypad column scan, 2-flop row synchronizer, debounce and decode to key/key_valid/key_held.
// Build option KEYPAD_AUTOREPEAT_EN: re-pulse key_valid every REPEAT_DLY cycles while the accepted key stays held.
module keypad_scanner #(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 50000,
    parameter int REPEAT_DLY   = 5000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key,
    output logic       key_valid,
    output logic       key_held
);

    // The dwell must cover the two synchronizer stages before the sample point.
    if (SCAN_DIV < 3 || DEBOUNCE_CNT < 1 || REPEAT_DLY < 1) begin : g_bad_cfg
        $error("keypad_scanner: invalid parameter set");
    end

    localparam int DW = $clog2(SCAN_DIV + 1);
    localparam int CW = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_CNT - 1);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} state_t;

    state_t        state_q;
    logic [3:0]    sync1_q;
    logic [3:0]    rs_q;
    logic [1:0]    cidx_q;
    logic [3:0]    col_q;
    logic [DW-1:0] dwell_q;
    logic [CW-1:0] cnt_q;
    logic [3:0]    rcap_q;
    logic [3:0]    key_q;
    logic          valid_q;
    logic          held_q;
    logic [1:0]    cidx_d;
    logic          single_low_d;

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int RW = $clog2(REPEAT_DLY + 1);
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_DLY - 1);
    logic [RW-1:0] rep_q;
`endif

    function automatic logic [3:0] col_drive(input logic [1:0] c);
        col_drive = ~(4'b0001 << c);
    endfunction

    function automatic logic [3:0] decode(input logic [3:0] rows_n, input logic [1:0] c);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!rows_n[i]) r = 2'(i);
        end
        case ({r, c})
            4'b00_00: decode = 4'h1;
            4'b00_01: decode = 4'h2;
            4'b00_10: decode = 4'h3;
            4'b00_11: decode = 4'hA;
            4'b01_00: decode = 4'h4;
            4'b01_01: decode = 4'h5;
            4'b01_10: decode = 4'h6;
            4'b01_11: decode = 4'hB;
            4'b10_00: decode = 4'h7;
            4'b10_01: decode = 4'h8;
            4'b10_10: decode = 4'h9;
            4'b10_11: decode = 4'hC;
            4'b11_00: decode = 4'h0;
            4'b11_01: decode = 4'hF;
            4'b11_10: decode = 4'hE;
            default:  decode = 4'hD;
        endcase
    endfunction

    assign cidx_d       = cidx_q + 2'd1;
    assign single_low_d = ($countones(~rcap_q) == 1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= SCAN;
            sync1_q <= 4'hF;
            rs_q    <= 4'hF;
            cidx_q  <= 2'd0;
            col_q   <= 4'b1110;
            dwell_q <= '0;
            cnt_q   <= '0;
            rcap_q  <= 4'hF;
            key_q   <= 4'h0;
            valid_q <= 1'b0;
            held_q  <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_q   <= '0;
`endif
        end else begin
            sync1_q <= row;
            rs_q    <= sync1_q;
            valid_q <= 1'b0;
            case (state_q)
                SCAN: begin
                    if (dwell_q == DWELL_LAST) begin
                        dwell_q <= '0;
                        if (rs_q != 4'hF) begin
                            state_q <= DEBOUNCE;
                            rcap_q  <= rs_q;
                            cnt_q   <= '0;
                        end else begin
                            cidx_q <= cidx_d;
                            col_q  <= col_drive(cidx_d);
                        end
                    end else begin
                        dwell_q <= dwell_q + 1'b1;
                    end
                end
                DEBOUNCE: begin
                    if (rs_q != rcap_q) begin
                        state_q <= SCAN;
                        cnt_q   <= '0;
                        cidx_q  <= cidx_d;
                        col_q   <= col_drive(cidx_d);
                    end else if (cnt_q == CNT_LAST) begin
                        cnt_q <= '0;
                        if (single_low_d) begin
                            key_q   <= decode(rcap_q, cidx_q);
                            valid_q <= 1'b1;
                            held_q  <= 1'b1;
                            state_q <= PRESSED;
                        end else begin
                            // Ghosting/multi-key: wait out a full release without reporting.
                            held_q  <= 1'b0;
                            state_q <= RELEASE;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                PRESSED: begin
                    if (rs_q == 4'hF) begin
                        state_q <= RELEASE;
                        cnt_q   <= '0;
`ifdef KEYPAD_AUTOREPEAT_EN
                        rep_q   <= '0;
                    end else if (rep_q == REP_LAST) begin
                        rep_q   <= '0;
                        valid_q <= 1'b1;
                    end else begin
                        rep_q <= rep_q + 1'b1;
`endif
                    end
                end
                RELEASE: begin
                    if (rs_q != 4'hF) begin
                        cnt_q <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= SCAN;
                        held_q  <= 1'b0;
                        cnt_q   <= '0;
                        cidx_q  <= cidx_d;
                        col_q   <= col_drive(cidx_d);
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= SCAN;
            endcase
        end
    end

    assign col       = col_q;
    assign key       = key_q;
    assign key_valid = valid_q;
    assign key_held  = held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: a keypad matrix model drives rows, expected key codes are queued per press.
module tb_keypad_scanner;

    logic       clk;
    logic       reset;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key;
    logic       key_valid;
    logic       key_held;

    logic [15:0] keys;          // keys[r*4+c] = pressed
    logic [3:0]  sb[$];
    int n_pass, n_total, m_pass, m_total, col_bad;

    keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CNT(8), .REPEAT_DLY(32)) dut (
        .clk(clk), .reset(reset), .row(row), .col(col),
        .key(key), .key_valid(key_valid), .key_held(key_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
    end

    // Monitor: pops the scoreboard on every key_valid strobe.
    always @(negedge clk) begin
        logic [3:0] exp_k;
        if (!(col == 4'b1110 || col == 4'b1101 || col == 4'b1011 || col == 4'b0111))
            col_bad = col_bad + 1;
        if (!reset && key_valid === 1'b1) begin
            m_total = m_total + 1;
            if (sb.size() == 0) begin
                $display("FAIL unexpected_key_valid: got key=%h, required no strobe", key);
            end else begin
                exp_k = sb.pop_front();
                if (key === exp_k) m_pass = m_pass + 1;
                else $display("FAIL key_on_valid: got %h, required %h", key, exp_k);
            end
        end
    end

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_total = n_total + 1;
        if (act === exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got %h, required %h", nm, act, exp);
    endtask

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_held(input logic v, input string nm);
        int i;
        i = 0;
        while (key_held !== v && i < 400) begin
            @(negedge clk);
            i++;
        end
        chk(nm, {7'd0, key_held}, {7'd0, v});
    endtask

    task automatic wait_sb_empty(input string nm);
        int i;
        i = 0;
        while (sb.size() != 0 && i < 400) begin
            @(negedge clk);
            i++;
        end
        chk(nm, 8'(sb.size()), 8'd0);
    endtask

    initial begin
        n_pass = 0; n_total = 0; m_pass = 0; m_total = 0; col_bad = 0;
        keys  = 16'h0;
        reset = 1'b1;
        run(3);
        chk("reset_col", {4'd0, col}, 8'h0E);
        chk("reset_key", {4'd0, key}, 8'h00);
        chk("reset_valid", {7'd0, key_valid}, 8'h00);
        chk("reset_held", {7'd0, key_held}, 8'h00);
        reset = 1'b0;
        run(5);

        // Single press r1/c2 -> 6
        sb.push_back(4'h6);
        keys[1*4+2] = 1'b1;
        wait_held(1'b1, "press6_held_rise");
        run(100);
        chk("press6_key", {4'd0, key}, 8'h06);
        chk("press6_held", {7'd0, key_held}, 8'h01);
        chk("press6_sb_empty", 8'(sb.size()), 8'd0);
        keys = 16'h0;
        run(6);
        chk("press6_held_during_release", {7'd0, key_held}, 8'h01);
        wait_held(1'b0, "press6_held_fall");
        chk("press6_key_kept", {4'd0, key}, 8'h06);
        run(10);

        // Bounce on r3/c0, then stable -> exactly one 0
        for (int t = 0; t < 10; t++) begin
            keys[3*4+0] = ~keys[3*4+0];
            run(3);
        end
        sb.push_back(4'h0);
        keys[3*4+0] = 1'b1;
        wait_held(1'b1, "bounce_held_rise");
        wait_sb_empty("bounce_valid");
        chk("bounce_key", {4'd0, key}, 8'h00);
        keys = 16'h0;
        wait_held(1'b0, "bounce_held_fall");
        run(10);

        // Two rows in column 3 (r0, r2) -> rejected
        keys[0*4+3] = 1'b1;
        keys[2*4+3] = 1'b1;
        run(80);
        chk("multi_key_unchanged", {4'd0, key}, 8'h00);
        chk("multi_held_low", {7'd0, key_held}, 8'h00);
        keys = 16'h0;
        run(40);

        // r0/c3 held, then r3/c1 added -> A only; F after first released
        sb.push_back(4'hA);
        keys[0*4+3] = 1'b1;
        wait_held(1'b1, "twokey_first_held");
        keys[3*4+1] = 1'b1;
        run(60);
        chk("twokey_first_key", {4'd0, key}, 8'h0A);
        chk("twokey_no_second", 8'(sb.size()), 8'd0);
        sb.push_back(4'hF);
        keys[0*4+3] = 1'b0;
        wait_sb_empty("twokey_second_valid");
        chk("twokey_second_key", {4'd0, key}, 8'h0F);
        keys = 16'h0;
        wait_held(1'b0, "twokey_held_fall");
        run(10);

        // Hold r2/c0 -> 7; repeats at 32, 64, 96 cycles with auto-repeat
        sb.push_back(4'h7);
`ifdef KEYPAD_AUTOREPEAT_EN
        sb.push_back(4'h7);
        sb.push_back(4'h7);
        sb.push_back(4'h7);
`endif
        keys[2*4+0] = 1'b1;
        wait_held(1'b1, "hold7_held_rise");
        run(100);
        chk("hold7_pulses", 8'(sb.size()), 8'd0);
        chk("hold7_key", {4'd0, key}, 8'h07);
        keys = 16'h0;
        wait_held(1'b0, "hold7_held_fall");
        run(10);

        // Async reset while a key is held
        sb.push_back(4'h1);
        keys[0] = 1'b1;
        wait_held(1'b1, "press1_held_rise");
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("async_reset_col", {4'd0, col}, 8'h0E);
        chk("async_reset_key", {4'd0, key}, 8'h00);
        chk("async_reset_valid", {7'd0, key_valid}, 8'h00);
        chk("async_reset_held", {7'd0, key_held}, 8'h00);
        run(2);
        keys = 16'h0;
        reset = 1'b0;
        run(40);
        chk("post_reset_key", {4'd0, key}, 8'h00);
        chk("final_sb_empty", 8'(sb.size()), 8'd0);
        chk("col_one_low_always", 8'(col_bad), 8'd0);

        n_pass  = n_pass + m_pass;
        n_total = n_total + m_total;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
